// File: rtl/pong_pkg.sv
// Shared Pong encodings: game states, ball status, winner codes and the ball origin.
`timescale 1ns/1ps
package pong_pkg;

    localparam logic [1:0] ST_START = 2'b00;
    localparam logic [1:0] ST_SERVE = 2'b01;
    localparam logic [1:0] ST_PLAY  = 2'b10;
    localparam logic [1:0] ST_DONE  = 2'b11;

    localparam logic [1:0] BALL_PLAYING = 2'b00;
    localparam logic [1:0] BALL_P1_WIN  = 2'b01;
    localparam logic [1:0] BALL_P2_WIN  = 2'b10;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;

    localparam int BALL_ORIGIN_X = 304;
    localparam int BALL_ORIGIN_Y = 224;

    // Saturating score increment; a score never wraps past 15.
    function automatic logic [3:0] score_inc(input logic [3:0] s);
        return (s == 4'hF) ? s : s + 4'd1;
    endfunction

endpackage

// File: rtl/pong_btn_edge.sv
// Single-register rising-edge detector for debounced level buttons.
`timescale 1ns/1ps
module pong_btn_edge (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    logic btn_q;

    // NOTE: the previous sample resets to 1 so a button held through reset is not seen as a press.
    always_ff @(posedge clk) begin
        if (rst) btn_q <= 1'b1;
        else     btn_q <= btn;
    end

    assign press = btn & ~btn_q;

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong match controller: serve timing, scoring and match-over detection.
// Optional build macro PONG_DONE_TIMEOUT_EN returns DONE to START after DONE_CYCLES.
`timescale 1ns/1ps
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int WIN_SCORE    = 7,
    parameter int SERVE_CYCLES = 25_000_000,
    parameter int CNT_W        = 26,
    parameter int DONE_CYCLES  = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_btn,
    input  logic [1:0] ball_status,
    output logic [1:0] state,
    output logic       serve,
    output logic [3:0] score1,
    output logic [3:0] score2,
    output logic [1:0] winner,
    output logic       point_strobe
);

    localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_CYCLES - 1);
    localparam logic [3:0]       WIN_LAST   = 4'(WIN_SCORE);

    generate
        if (WIN_SCORE < 1 || WIN_SCORE > 15)
            $error("WIN_SCORE out of range 1..15");
        if (SERVE_CYCLES < 2 || (SERVE_CYCLES - 1) >= (1 << CNT_W))
            $error("SERVE_CYCLES must be >= 2 and fit in CNT_W bits");
        if (DONE_CYCLES < 1 || (DONE_CYCLES - 1) >= (1 << CNT_W))
            $error("DONE_CYCLES must be >= 1 and fit in CNT_W bits");
    endgenerate

    logic             start_press;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       next1;
    logic [3:0]       next2;

    pong_btn_edge u_start_edge (
        .clk   (clk),
        .rst   (rst),
        .btn   (start_btn),
        .press (start_press)
    );

    assign next1 = score_inc(score1);
    assign next2 = score_inc(score2);

`ifdef PONG_DONE_TIMEOUT_EN
    localparam logic [CNT_W-1:0] DONE_LAST = CNT_W'(DONE_CYCLES - 1);
`endif

    // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_START;
            serve        <= 1'b0;
            score1       <= 4'd0;
            score2       <= 4'd0;
            winner       <= WIN_NONE;
            point_strobe <= 1'b0;
            cnt          <= '0;
        end else begin
            point_strobe <= 1'b0;
            case (state)
                ST_START: begin
                    if (start_press) begin
                        state  <= ST_SERVE;
                        score1 <= 4'd0;
                        score2 <= 4'd0;
                        winner <= WIN_NONE;
                        serve  <= 1'b0;
                        cnt    <= '0;
                    end
                end

                ST_SERVE: begin
                    if (cnt == SERVE_LAST) begin
                        state <= ST_PLAY;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                // Leaving PLAY on the scoring cycle keeps a held status from scoring twice.
                ST_PLAY: begin
                    case (ball_status)
                        BALL_P1_WIN: begin
                            score1       <= next1;
                            serve        <= 1'b0;
                            point_strobe <= 1'b1;
                            cnt          <= '0;
                            if (next1 == WIN_LAST) begin
                                state  <= ST_DONE;
                                winner <= WIN_P1;
                            end else begin
                                state <= ST_SERVE;
                            end
                        end
                        BALL_P2_WIN: begin
                            score2       <= next2;
                            serve        <= 1'b1;
                            point_strobe <= 1'b1;
                            cnt          <= '0;
                            if (next2 == WIN_LAST) begin
                                state  <= ST_DONE;
                                winner <= WIN_P2;
                            end else begin
                                state <= ST_SERVE;
                            end
                        end
                        default: ;
                    endcase
                end

                ST_DONE: begin
                    if (start_press) begin
                        state  <= ST_SERVE;
                        score1 <= 4'd0;
                        score2 <= 4'd0;
                        winner <= WIN_NONE;
                        serve  <= 1'b0;
                        cnt    <= '0;
                    end
`ifdef PONG_DONE_TIMEOUT_EN
                    else if (cnt == DONE_LAST) begin
                        state  <= ST_START;
                        score1 <= 4'd0;
                        score2 <= 4'd0;
                        winner <= WIN_NONE;
                        cnt    <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
`endif
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Self-checking bench for pong_game_ctrl: directed match scenarios plus random play against a reference model.
`timescale 1ns/1ps
module tb_pong_game_ctrl;

    localparam int SERVE_CYCLES = 4;
    localparam int WIN_SCORE    = 3;
    localparam int DONE_CYCLES  = 8;
    localparam int CNT_W        = 4;

    localparam int M_START = 0;
    localparam int M_SERVE = 1;
    localparam int M_PLAY  = 2;
    localparam int M_DONE  = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_btn;
    logic [1:0] ball_status;
    logic [1:0] state;
    logic       serve;
    logic [3:0] score1;
    logic [3:0] score2;
    logic [1:0] winner;
    logic       point_strobe;

    pong_game_ctrl #(
        .WIN_SCORE    (WIN_SCORE),
        .SERVE_CYCLES (SERVE_CYCLES),
        .CNT_W        (CNT_W),
        .DONE_CYCLES  (DONE_CYCLES)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start_btn    (start_btn),
        .ball_status  (ball_status),
        .state        (state),
        .serve        (serve),
        .score1       (score1),
        .score2       (score2),
        .winner       (winner),
        .point_strobe (point_strobe)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: phase, remaining serve cycles, idle time in DONE, plain integer scores.
    int m_state  = M_START;
    int m_serve  = 0;
    int m_s1     = 0;
    int m_s2     = 0;
    int m_win    = 0;
    int m_strobe = 0;
    int m_left   = 0;
    int m_idle   = 0;
    int m_prev   = 1;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_s1  = 0;
        m_s2  = 0;
        m_win = 0;
    endtask

    task automatic model_step();
        bit press;
        press  = (start_btn == 1'b1) && (m_prev == 0);
        m_prev = rst ? 1 : int'(start_btn);
        if (rst) begin
            m_state  = M_START;
            m_serve  = 0;
            m_strobe = 0;
            m_idle   = 0;
            model_clear();
        end else begin
            m_strobe = 0;
            case (m_state)
                M_START: if (press) begin
                    model_clear();
                    m_state = M_SERVE; m_serve = 0; m_left = SERVE_CYCLES;
                end
                M_SERVE: begin
                    m_left--;
                    if (m_left == 0) m_state = M_PLAY;
                end
                M_PLAY: begin
                    if (ball_status == 2'b01) begin
                        m_s1 = (m_s1 < 15) ? m_s1 + 1 : 15;
                        m_serve = 0; m_strobe = 1;
                        if (m_s1 == WIN_SCORE) begin
                            m_state = M_DONE; m_win = 1; m_idle = 0;
                        end else begin
                            m_state = M_SERVE; m_left = SERVE_CYCLES;
                        end
                    end else if (ball_status == 2'b10) begin
                        m_s2 = (m_s2 < 15) ? m_s2 + 1 : 15;
                        m_serve = 1; m_strobe = 1;
                        if (m_s2 == WIN_SCORE) begin
                            m_state = M_DONE; m_win = 2; m_idle = 0;
                        end else begin
                            m_state = M_SERVE; m_left = SERVE_CYCLES;
                        end
                    end
                end
                default: begin
                    if (press) begin
                        model_clear();
                        m_state = M_SERVE; m_serve = 0; m_left = SERVE_CYCLES;
                    end else begin
`ifdef PONG_DONE_TIMEOUT_EN
                        m_idle++;
                        if (m_idle == DONE_CYCLES) begin
                            model_clear();
                            m_state = M_START;
                        end
`endif
                    end
                end
            endcase
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("state",  int'(state),        m_state);
        check("serve",  int'(serve),        m_serve);
        check("score1", int'(score1),       m_s1);
        check("score2", int'(score2),       m_s2);
        check("winner", int'(winner),       m_win);
        check("strobe", int'(point_strobe), m_strobe);
    endtask

    task automatic run_to_play();
        for (int k = 0; k < 20 && state != 2'b10; k++) tick();
        check("reach_play", int'(state), M_PLAY);
    endtask

    task automatic press_start();
        start_btn = 1'b0;
        tick();
        start_btn = 1'b1;
        tick();
    endtask

    initial begin
        int strobes;
        rst = 1'b1;
        start_btn = 1'b1;
        ball_status = 2'b00;
        repeat (3) tick();
        rst = 1'b0;

        // Button held through reset must not start a match.
        for (int i = 0; i < 10; i++) begin
            tick();
            check("hold_start", int'(state), M_START);
            check("hold_strobe", int'(point_strobe), 0);
        end

        press_start();
        check("to_serve", int'(state), M_SERVE);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("serve_len", int'(state), M_SERVE);
        end
        tick();
        check("to_play", int'(state), M_PLAY);
        check("serve_dir0", int'(serve), 0);

        // Player 1 status held for three cycles scores exactly once.
        ball_status = 2'b01;
        strobes = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            strobes += int'(point_strobe);
        end
        check("strobe_once", strobes, 1);
        check("p1_once", int'(score1), 1);
        check("p1_serve_state", int'(state), M_SERVE);
        ball_status = 2'b00;
        run_to_play();

        ball_status = 2'b11;
        repeat (2) tick();
        check("reserved_s1", int'(score1), 1);
        check("reserved_s2", int'(score2), 0);
        check("reserved_state", int'(state), M_PLAY);

        ball_status = 2'b10;
        tick();
        check("p2_first", int'(score2), 1);
        ball_status = 2'b00;
        run_to_play();
        check("serve_dir1", int'(serve), 1);

        ball_status = 2'b10;
        tick();
        ball_status = 2'b00;
        run_to_play();
        ball_status = 2'b10;
        tick();
        ball_status = 2'b00;
        check("match_done", int'(state), M_DONE);
        check("match_winner", int'(winner), 2);
        check("match_s2", int'(score2), 3);
        check("match_s1", int'(score1), 1);

`ifdef PONG_DONE_TIMEOUT_EN
        for (int i = 0; i < 7; i++) begin
            tick();
            check("done_hold", int'(state), M_DONE);
        end
        tick();
        check("timeout_start", int'(state), M_START);
        check("timeout_winner", int'(winner), 0);
`else
        repeat (100) tick();
        check("done_forever", int'(state), M_DONE);
        check("done_winner", int'(winner), 2);
`endif

        press_start();
        check("restart_state", int'(state), M_SERVE);
        check("restart_s1", int'(score1), 0);
        check("restart_s2", int'(score2), 0);
        check("restart_winner", int'(winner), 0);

        // Reset mid-SERVE with player 1 on two points.
        run_to_play();
        ball_status = 2'b01;
        tick();
        ball_status = 2'b00;
        run_to_play();
        ball_status = 2'b01;
        tick();
        ball_status = 2'b00;
        tick();
        check("pre_rst_s1", int'(score1), 2);
        rst = 1'b1;
        tick();
        check("rst_state", int'(state), M_START);
        check("rst_s1", int'(score1), 0);
        check("rst_serve", int'(serve), 0);
        rst = 1'b0;
        tick();
        check("rst_no_press", int'(state), M_START);
        press_start();
        check("rst_serve_again", int'(state), M_SERVE);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_serve_len", int'(state), M_SERVE);
        end
        tick();
        check("rst_to_play", int'(state), M_PLAY);

        // Random play against the model.
        for (int i = 0; i < 2500; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 9) == 0) start_btn = ~start_btn;
            ball_status = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
Top-level match controller for Pong. It consumes the ball engine's 2-bit ball status and drives the 2-bit game state (START/SERVE/PLAY/DONE) and the serve-direction bit back to the ball engine. It keeps both players' scores, timed serve intervals and match-over detection. It also emits a one-cycle point strobe for the audio and display blocks.

Parameters:
WIN_SCORE, 7, points needed to win the match; legal range 1..15.
SERVE_CYCLES, 25_000_000, number of clk cycles spent in SERVE before PLAY; minimum 2, so ball status clears first.
CNT_W, 26, width of the internal interval counter; must hold SERVE_CYCLES-1 and DONE_CYCLES-1.
DONE_CYCLES, 50_000_000, DONE auto-return interval; used only with PONG_DONE_TIMEOUT_EN.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
start_btn  in  1  debounced start button, level
ball_status  in  2  00 PLAYING, 01 PLAYER1WIN, 10 PLAYER2WIN, 11 reserved
state  out  2  00 START, 01 SERVE, 10 PLAY, 11 DONE
serve  out  1  0: ball launches +X toward player 2; 1: ball launches -X toward player 1
score1  out  4  player 1 (left) score
score2  out  4  player 2 (right) score
winner  out  2  00 none, 01 player 1, 10 player 2
point_strobe  out  1  one-cycle pulse on every scored point

Behaviour:
- Reset (state and outputs): state=START, serve=0, score1=score2=0, winner=00, point_strobe=0, counter=0.
- Reset (button edge detector): the previous-sample register resets to 1, so a button held through reset does not fire.
- All outputs are registered; all state changes take effect one cycle after the qualifying input.
- start_press = start_btn & ~start_btn_q, sampled every cycle in every state.
- START: on start_press -> SERVE; clear score1, score2 and winner; serve=0; counter=0.
- SERVE: counter increments every cycle. When counter==SERVE_CYCLES-1 -> PLAY and counter=0, so SERVE lasts exactly SERVE_CYCLES cycles. start_press is ignored.
- PLAY, ball_status==01: score1+1; serve=0 (scorer serves); point_strobe=1 for one cycle.
  - If the new score1==WIN_SCORE -> DONE with winner=01.
  - Otherwise -> SERVE with counter=0.
- PLAY, ball_status==10: symmetric; score2+1, serve=1, winner=10 on reaching WIN_SCORE.
- PLAY, ball_status 00 or 11: no action; 11 is never scored. start_press is ignored.
- Scoring happens only in PLAY, on the first cycle status is non-zero; the exit from PLAY guarantees no double count.
- Scores saturate at 15 and never wrap, though WIN_SCORE<=15 makes this unreachable in legal configurations.
- DONE: scores and winner are held. On start_press -> SERVE; clear scores and winner; serve=0; counter=0.
- Reset has priority over every event, including mid-PLAY and mid-SERVE; the game returns to START and scores clear.
- point_strobe is high only on the cycle the score register updates; it is 0 otherwise.

Optional Feature:
PONG_DONE_TIMEOUT_EN
- Defined: in DONE the counter increments. When counter==DONE_CYCLES-1 -> START; scores and winner clear; counter=0. A start_press in DONE before timeout still goes directly to SERVE, and it wins if both occur on the same cycle.
- Undefined: DONE holds indefinitely until start_press; the counter stays 0 in DONE, and DONE_CYCLES is unused.

Decomposition:
- Shared package pong_pkg:
  - game state encodings START/SERVE/PLAY/DONE;
  - ball status encodings PLAYING/PLAYER1WIN/PLAYER2WIN;
  - winner encodings;
  - ball origin constants 304/224.
- Sub-module pong_btn_edge (one-register rising-edge detector, reset value 1), reusable for the paddle and pause buttons.
- The scoring and FSM logic stay in pong_game_ctrl.

Test Plan:
All scenarios use SERVE_CYCLES=4, WIN_SCORE=3, DONE_CYCLES=8.
- Reset with start_btn held high, then keep it high for 10 cycles -> state stays START (00), scores 0, point_strobe never 1.
- start_btn 0->1 in START -> state=SERVE next cycle. It stays SERVE exactly 4 cycles, then PLAY (10); serve=0.
- In PLAY, drive ball_status=01 for 3 cycles -> score1=1 (not 3); point_strobe high exactly 1 cycle; state=SERVE; serve=0.
- In PLAY, drive ball_status=10 -> score2 increments; serve=1 on the next SERVE.
- Drive ball_status=11 in PLAY -> no score change.
- Score 3 points for player 2 -> after the third point state=DONE, winner=10, score2=3, score1 unchanged. start_press then -> SERVE with scores and winner cleared.
- PONG_DONE_TIMEOUT_EN defined, idle in DONE -> after exactly 8 cycles state=START, winner=00.
- Macro undefined -> still DONE after 100 cycles.
- Assert rst mid-SERVE with score1=2 -> next cycle state=START, scores 0, serve=0, counter restarts on the next serve.
